// File: rtl/cgr_pkg.sv
// Shared FSM state encoding and address-to-index helper for the CGR histogram.
package cgr_pkg;

    typedef logic [0:0] cgr_state_t;

    localparam cgr_state_t IDLE  = 1'b0;
    localparam cgr_state_t CLEAR = 1'b1;

    localparam int CGR_MAX_AW = 33;

    // Drops the separator bit between the x and y fields: {x, 1'b0, y} -> {x, y}.
    function automatic logic [31:0] cgr_strip(input logic [CGR_MAX_AW-1:0] addr, input int dlen);
        logic [CGR_MAX_AW-1:0] lo_mask;
        logic [CGR_MAX_AW-1:0] idx;
        lo_mask = (CGR_MAX_AW'(1) << dlen) - CGR_MAX_AW'(1);
        idx     = ((addr >> (dlen + 1)) << dlen) | (addr & lo_mask);
        return idx[31:0];
    endfunction

endpackage

// File: rtl/cgr_hist_mem.sv
// Counter table: one increment port, one clear port, write-first registered read.
// Define CGR_HIST_SAT_EN to saturate counters instead of wrapping.
module cgr_hist_mem #(
    parameter int DATA_LEN = 3,
    parameter int CNT_W    = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  inc_en,
    input  logic [2*DATA_LEN-1:0] inc_idx,
    input  logic                  clr_en,
    input  logic [2*DATA_LEN-1:0] clr_idx,
    input  logic                  rd_en,
    input  logic [2*DATA_LEN-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [CNT_W-1:0]      rd_data
);

    localparam int IDX_W = 2 * DATA_LEN;
    localparam int DEPTH = 1 << IDX_W;

    logic [CNT_W-1:0] cnt [DEPTH];
    logic [CNT_W-1:0] cur;
    logic [CNT_W-1:0] inc_val;
    logic [CNT_W-1:0] rd_next;

    assign cur = cnt[inc_idx];

`ifdef CGR_HIST_SAT_EN
    assign inc_val = (&cur) ? cur : cur + CNT_W'(1);
`else
    assign inc_val = cur + CNT_W'(1);
`endif

    // Clear is applied after the increment so a sweep always leaves zero behind.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (inc_en) begin
                cnt[inc_idx] <= inc_val;
            end
            if (clr_en) begin
                cnt[clr_idx] <= '0;
            end
        end
    end

    always_comb begin
        rd_next = cnt[rd_idx];
        if (inc_en && (inc_idx == rd_idx)) begin
            rd_next = inc_val;
        end
        if (clr_en && (clr_idx == rd_idx)) begin
            rd_next = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_next;
            end
        end
    end

endmodule

// File: rtl/cgr_hist.sv
// CGR frequency histogram: two-stage count pipeline, clear-sweep FSM, one-cycle readout.
// Optional saturating counters via CGR_HIST_SAT_EN (default: wrap).
module cgr_hist
    import cgr_pkg::*;
#(
    parameter int DATA_LEN = 3,
    parameter int CNT_W    = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [2*DATA_LEN:0]   addr_in,
    input  logic                  wen_in,
    input  logic                  clr,
    input  logic                  rd_en,
    input  logic [2*DATA_LEN-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [CNT_W-1:0]      rd_data,
    output logic                  busy,
    output logic                  err
);

    localparam int IDX_W = 2 * DATA_LEN;
    localparam int AW    = 2 * DATA_LEN + 1;

    cgr_state_t       state;
    logic [IDX_W-1:0] sweep_idx;

    logic             s1_wen;
    logic             s1_vld;
    logic [AW-1:0]    s1_addr;
    logic [IDX_W-1:0] s1_idx;

    assign s1_idx = IDX_W'(cgr_strip(CGR_MAX_AW'(s1_addr), DATA_LEN));
    assign busy   = (state == CLEAR);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_wen  <= 1'b0;
            s1_vld  <= 1'b0;
            s1_addr <= '0;
        end else begin
            s1_wen  <= wen_in;
            s1_vld  <= wen_in && (state == IDLE);
            s1_addr <= addr_in;
        end
    end

    // A set separator bit is flagged but the stripped index is still counted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err <= 1'b0;
        end else if (s1_wen && s1_addr[DATA_LEN]) begin
            err <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            sweep_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        state     <= CLEAR;
                        sweep_idx <= '0;
                    end
                end
                CLEAR: begin
                    sweep_idx <= sweep_idx + IDX_W'(1);
                    if (&sweep_idx) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    cgr_hist_mem #(
        .DATA_LEN (DATA_LEN),
        .CNT_W    (CNT_W)
    ) u_mem (
        .CLK      (CLK),
        .RST      (RST),
        .inc_en   (s1_vld),
        .inc_idx  (s1_idx),
        .clr_en   (busy),
        .clr_idx  (sweep_idx),
        .rd_en    (rd_en),
        .rd_idx   (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

endmodule

// File: tb/tb_cgr_hist.sv
// Bench for cgr_hist: vector table, randomized run against a count model, clear and saturation sequences.
module tb_cgr_hist;

    logic        CLK = 1'b0;
    logic        RST;
    logic [6:0]  addr_in;
    logic        wen_in;
    logic        clr;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;

    cgr_hist #(.DATA_LEN(3), .CNT_W(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .addr_in  (addr_in),
        .wen_in   (wen_in),
        .clr      (clr),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .busy     (busy),
        .err      (err)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        wen;
        logic [6:0]  addr;
        logic        rd;
        logic [5:0]  ra;
        logic        ev;
        logic [15:0] ed;
        logic        ee;
    } vec_t;

    vec_t tbl[$];
    int   model[64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle(input logic w, input logic [6:0] a, input logic r,
                         input logic [5:0] ra, input logic c);
        @(negedge CLK);
        wen_in = w; addr_in = a; rd_en = r; rd_addr = ra; clr = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST = 1'b1; wen_in = 0; addr_in = 0; rd_en = 0; rd_addr = 0; clr = 0;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
    endtask

    function automatic int next_count(input int v);
`ifdef CGR_HIST_SAT_EN
        return (v >= 65535) ? 65535 : v + 1;
`else
        return (v + 1) % 65536;
`endif
    endfunction

    function automatic int strip(input logic [6:0] a);
        return int'({a[6:4], a[2:0]});
    endfunction

    initial begin
        logic [6:0] a;
        logic [5:0] ra;
        logic       w, r;
        int         exp_d, bcnt, k;
        bit         merr;

        RST = 1'b1; wen_in = 0; addr_in = 0; rd_en = 0; rd_addr = 0; clr = 0;
        #1;
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        @(negedge CLK);
        RST = 1'b0;

        // rst wen addr rd ra | ev ed ee
        tbl.push_back('{1, 0, 7'h00, 0, 6'd0,  0, 16'd0, 0});
        tbl.push_back('{0, 1, 7'h44, 0, 6'd0,  0, 16'd0, 0});
        tbl.push_back('{0, 0, 7'h00, 0, 6'd0,  0, 16'd0, 0});
        tbl.push_back('{0, 0, 7'h00, 1, 6'd36, 1, 16'd1, 0});
        tbl.push_back('{0, 0, 7'h00, 0, 6'd0,  0, 16'd0, 0});
        tbl.push_back('{1, 0, 7'h00, 0, 6'd0,  0, 16'd0, 0});
        for (int i = 0; i < 5; i++) tbl.push_back('{0, 1, 7'h44, 0, 6'd0, 0, 16'd0, 0});
        tbl.push_back('{0, 0, 7'h00, 1, 6'd36, 1, 16'd5, 0});
        tbl.push_back('{0, 0, 7'h00, 0, 6'd0,  0, 16'd0, 0});
        tbl.push_back('{1, 0, 7'h00, 0, 6'd0,  0, 16'd0, 0});
        tbl.push_back('{0, 1, 7'h44, 0, 6'd0,  0, 16'd0, 0});
        tbl.push_back('{0, 1, 7'h44, 0, 6'd0,  0, 16'd0, 0});
        tbl.push_back('{0, 1, 7'h44, 1, 6'd36, 1, 16'd2, 0});
        tbl.push_back('{0, 0, 7'h00, 1, 6'd36, 1, 16'd3, 0});
        tbl.push_back('{0, 0, 7'h00, 1, 6'd36, 1, 16'd3, 0});
        tbl.push_back('{0, 1, 7'h4C, 0, 6'd0,  0, 16'd0, 0});
        tbl.push_back('{0, 0, 7'h00, 0, 6'd0,  0, 16'd0, 1});
        tbl.push_back('{0, 0, 7'h00, 1, 6'd36, 1, 16'd4, 1});
        tbl.push_back('{0, 0, 7'h00, 0, 6'd0,  0, 16'd0, 1});
        tbl.push_back('{1, 0, 7'h00, 0, 6'd0,  0, 16'd0, 0});
        tbl.push_back('{0, 0, 7'h00, 1, 6'd36, 1, 16'd0, 0});

        foreach (tbl[i]) begin
            if (tbl[i].rst) apply_reset();
            else cycle(tbl[i].wen, tbl[i].addr, tbl[i].rd, tbl[i].ra, 1'b0);
            check($sformatf("vec%0d_rd_valid", i), rd_valid, tbl[i].ev);
            check($sformatf("vec%0d_err", i), err, tbl[i].ee);
            check($sformatf("vec%0d_busy", i), busy, 0);
            if (tbl[i].ev) check($sformatf("vec%0d_rd_data", i), rd_data, tbl[i].ed);
        end

        // Randomized counting against a plain per-index tally.
        apply_reset();
        foreach (model[i]) model[i] = 0;
        merr = 0;
        for (int n = 0; n < 1500; n++) begin
            w  = 1'($urandom_range(0, 1));
            a  = 7'($urandom);
            a[3] = ($urandom_range(0, 15) == 0);
            r  = 1'($urandom_range(0, 1));
            ra = 6'($urandom);
            exp_d = model[ra];
            cycle(w, a, r, ra, 1'b0);
            check("rand_rd_valid", rd_valid, r);
            if (r) check($sformatf("rand_rd_data[%0d]", ra), rd_data, exp_d);
            if (w) begin
                model[strip(a)] = next_count(model[strip(a)]);
                if (a[3]) merr = 1;
            end
        end
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("rand_err", err, merr);

        // Clear sweep: in-flight update, ignored clr, dropped strobe, ordered zeroing.
        apply_reset();
        cycle(1, 7'h77, 0, 0, 0);
        cycle(1, 7'h44, 0, 0, 0);
        cycle(1, 7'h00, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        check("clr_busy_rise", busy, 1);
        bcnt = 1;
        k = 0;
        while (k < 200) begin
            k++;
            if (k == 3)       cycle(1, 7'h44, 0, 0, 0);
            else if (k == 5)  cycle(0, 0, 1, 6'd0, 0);
            else if (k == 6)  cycle(0, 0, 1, 6'd63, 0);
            else if (k == 10) cycle(0, 0, 0, 0, 1);
            else              cycle(0, 0, 0, 0, 0);
            if (k == 5) check("clr_swept_idx0", rd_data, 0);
            if (k == 6) check("clr_unswept_idx63", rd_data, 1);
            if (busy) bcnt++;
            else break;
        end
        check("clr_busy_cycles", bcnt, 64);
        for (int i = 0; i < 64; i++) begin
            cycle(0, 0, 1, 6'(i), 0);
            check($sformatf("clr_zero[%0d]", i), rd_data, 0);
        end
        cycle(1, 7'h44, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 6'd36, 0);
        check("post_clr_count", rd_data, 1);

        // Asynchronous reset in the middle of a sweep.
        cycle(1, 7'h4C, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
        check("abort_pre_busy", busy, 1);
        check("abort_pre_err", err, 1);
        #2;
        RST = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_err", err, 0);
        @(negedge CLK);
        RST = 1'b0;
        cycle(0, 0, 1, 6'd36, 0);
        check("abort_table_zero", rd_data, 0);
        check("abort_busy_after", busy, 0);

        // Fill index 0 to the top of the counter range, then one more.
        apply_reset();
        for (int i = 0; i < 65535; i++) cycle(1, 7'h00, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 6'd0, 0);
        check("fill_max", rd_data, 65535);
        cycle(1, 7'h00, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 6'd0, 0);
        check("fill_overflow", rd_data, next_count(65535));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cgr_hist.md
CGR_HIST -- requirements
Module: cgr_hist

Interface
REQ-001 The block SHALL have parameter DATA_LEN, default 3: bits per CGR axis; must match the upstream address generator.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of each frequency counter.
REQ-003 The block SHALL have input CLK, 1 bit: clock; all state updates on the rising edge.
REQ-004 The block SHALL have input RST, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have input addr_in, 2*DATA_LEN+1 bits: CGR address {x, 1'b0, y} from the upstream stage.
REQ-006 The block SHALL have input wen_in, 1 bit: count strobe; addr_in is valid when high.
REQ-007 The block SHALL have input clr, 1 bit: single-cycle pulse that starts a table clear sweep.
REQ-008 The block SHALL have input rd_en, 1 bit: readout request.
REQ-009 The block SHALL have input rd_addr, 2*DATA_LEN bits: readout index {x,y}.
REQ-010 The block SHALL have output rd_valid, 1 bit: rd_data is valid.
REQ-011 The block SHALL have output rd_data, CNT_W bits: counter value.
REQ-012 The block SHALL have output busy, 1 bit: clear sweep in progress.
REQ-013 The block SHALL have output err, 1 bit: sticky flag for a malformed address.

Function
REQ-014 The block SHALL keep a table of 2^(2*DATA_LEN) counters, indexed by {x,y}, taken as addr_in with the middle bit removed.
REQ-015 Stage 1 SHALL register wen_in, addr_in, and a qualified strobe equal to wen_in AND the FSM being in IDLE.
REQ-016 Stage 2 SHALL increment the indexed counter one cycle after capture; the updated value SHALL be readable two edges after strobe sampling.
REQ-017 Strobes on consecutive cycles to the same index SHALL each count, with no lost update.
REQ-018 When wen_in is high and the middle bit of addr_in is 1, the block SHALL set err, which stays set until reset, and SHALL still count using the stripped index.
REQ-019 FSM states: IDLE and CLEAR.
REQ-020 IDLE -> CLEAR on clr, with busy high from the next cycle.
REQ-021 CLEAR SHALL zero one entry per cycle, index 0 upward, then return to IDLE after the last index; busy SHALL be high for exactly 2^(2*DATA_LEN) cycles.
REQ-022 A clr pulse received in CLEAR SHALL be ignored.
REQ-023 Strobes sampled while busy SHALL be dropped, with no counting.
REQ-024 A stage-2 update in flight when clr arrives SHALL complete before entry 0 is cleared.
REQ-025 Readout: rd_en at edge k SHALL give rd_valid=1 and rd_data=table[rd_addr] during the cycle after edge k, for one cycle.
REQ-026 Readout SHALL be allowed in any state.
REQ-027 If stage 2 writes the index being read on the same edge, rd_data SHALL return the post-increment value (write-first).
REQ-028 Readout during CLEAR SHALL return 0 for indices already swept.

Reset
REQ-029 While RST is high, all counters, rd_data, rd_valid, busy, err and the pipeline registers SHALL be 0, and the FSM SHALL be in IDLE, with effect independent of CLK.
REQ-030 RST asserted during CLEAR SHALL abort the sweep; the table is still zeroed by reset.

Configuration
REQ-031 With CGR_HIST_SAT_EN defined, counters SHALL saturate at 2^CNT_W-1.
REQ-032 With CGR_HIST_SAT_EN not defined, counters SHALL wrap modulo 2^CNT_W.

Structure
REQ-033 Shared package cgr_pkg SHALL hold the FSM state typedef (IDLE, CLEAR) and the index-strip function from address to {x,y}.
REQ-034 The counter array with its write-first read port SHALL be the sub-module cgr_hist_mem.
REQ-035 The pipeline and FSM SHALL stay in cgr_hist.

Verification (DATA_LEN=3, CNT_W=16)
REQ-036 Reset, then wen_in=1 with addr_in=7'h44 for one cycle, then rd_en with rd_addr=6'd36 two cycles later -> rd_data=1, rd_valid=1 for one cycle, err=0.
REQ-037 Five back-to-back strobes at 7'h44 -> read of index 36 returns 5.
REQ-038 Fill index 0 to 65535, then one more strobe -> with CGR_HIST_SAT_EN: 65535; without it: 0.
REQ-039 Count entries, pulse clr, strobe 7'h44 at sweep cycle 3 -> busy high for 64 cycles; all reads return 0 afterwards; the dropped strobe is not counted.
REQ-040 Strobe with addr_in=7'h4C (middle bit 1) -> err=1 persists; index 36 is incremented; RST clears err.
REQ-041 Strobe to index 36 on the same edge as a rd_en at index 36 holding 2 -> rd_data=3.
